ttc_trigger_packer: RTL and testbench
=====================================

Name: ttc_trigger_packer

Overview:
Upstream neighbour of the TTC trigger processing FSM. Converts TTC-decoded trigger strobes into 128-bit trigger-FIFO words:
- global trigger number
- channel event number
- type
- 44-bit timestamp
- empty-event / empty-payload flags
- XADC alarms

Also issues a per-event acquisition strobe to the channel acquisition logic, and accounts for triggers lost to FIFO backpressure.

Parameters:
DROP_CNT_WIDTH, 16, width of saturating dropped-trigger counter
TS_WIDTH, 44, timestamp counter width; must be 44 to match the word format

Ports:
clk  in  1  125 MHz clock
reset  in  1  synchronous, active-high
ttc_trigger  in  1  one-cycle trigger strobe from TTC decoder
ttc_trig_type  in  5  trigger type, valid with ttc_trigger
ttc_counter_reset  in  1  one-cycle strobe: clear trig_num, event_num, timestamp
type_enable  in  32  bit t=0 marks type t as empty event
payload_enable  in  32  bit t=0 marks type t as empty payload
xadc_alarms  in  4  live XADC alarm bits
trig_fifo_data  out  128  packed trigger word
trig_fifo_valid  out  1  word available
trig_fifo_ready  in  1  FIFO accepts word
acq_trigger  out  1  one-cycle strobe to acquisition logic
acq_trig_type  out  5  type accompanying acq_trigger
acq_trig_num  out  24  trigger number accompanying acq_trigger
dropped_count  out  DROP_CNT_WIDTH  saturating count of dropped triggers
overflow  out  1  sticky: at least one trigger dropped

Behaviour:
- Reset values:
  - All outputs 0.
  - Internal trig_num, event_num and timestamp are 0.
  - FSM in EMPTY.
- Timestamp:
  - Free-running 44-bit counter, +1 per cycle, wraps 2^44-1 -> 0.
  - ttc_counter_reset loads 0.
- Trigger accept, ttc_trigger high in cycle N:
  - trig_num <= trig_num+1 (24-bit wrap; first trigger after reset = 1).
  - The word captures the timestamp value present in cycle N and xadc_alarms sampled in cycle N.
  - empty_event = ~type_enable[type].
  - empty_payload = ~payload_enable[type] & ~empty_event.
  - If not empty_event: event_num <= event_num+1 (wrap), and the word carries the incremented value. Empty events carry the current event_num, unincremented.
- Word layout:
  - [127:103] 0
  - [102] empty_payload
  - [101:98] xadc_alarms
  - [97] empty_event
  - [96:92] type
  - [91:68] event_num
  - [67:44] trig_num
  - [43:0] timestamp
- FSM, one-entry output buffer:
  - EMPTY: valid=0. Trigger -> load word -> FULL.
  - FULL: valid=1, data stable.
    - ready & no trigger -> EMPTY.
    - ready & trigger -> load new word, stay FULL, valid stays 1.
    - ~ready & trigger -> DROP.
- DROP: the trigger is discarded.
  - trig_num still increments, keeping global numbering aligned with TTC.
  - event_num does not increment.
  - No acq_trigger.
  - dropped_count +1, saturating at all-ones.
  - overflow <= 1 until reset.
- Latency:
  - trig_fifo_valid and acq_trigger assert in cycle N+1.
  - acq_trigger pulses for exactly one cycle only for accepted non-empty events, with acq_trig_num equal to the word's trig_num.
- Counter reset:
  - ttc_counter_reset with ttc_trigger in the same cycle: the reset applies first; that trigger gets trig_num=1, event_num=1 (if non-empty), timestamp 0.
  - ttc_counter_reset never alters a buffered word.
- dropped_count and overflow clear only on reset.

Optional Feature:
TRIG_XADC_ALARMS_EN
- Defined: bits [101:98] carry sampled xadc_alarms.
- Undefined: xadc_alarms port is still present but ignored; bits [101:98] are forced 0.

Decomposition:
- Shared package trigger_pkg holds:
  - bit-position constants for the 128-bit trigger word (EMPTY_PAYLOAD_BIT=102, XADC_HI/LO, EMPTY_EVENT_BIT=97, TYPE_HI/LO, EVNUM_HI/LO, TRIGNUM_HI/LO, TS_HI/LO)
  - acq word layout
  - FSM state encoding
- The trigger processor consumes the same constants.
- One natural sub-module: trigger_word_buffer, the one-entry valid/ready holding register with drop detection.

Test Plan:
1. Reset, type_enable=payload_enable=all-ones, ttc_trigger type=3 at timestamp 100, ready=1 -> next cycle valid=1, trig_num=1, event_num=1, type=3, ts=100, flags 0; acq_trigger pulse with acq_trig_num=1.
2. type_enable[5]=0, trigger type 5 as 2nd trigger -> word empty_event=1, event_num=previous (1), trig_num=2, no acq_trigger.
3. payload_enable[7]=0, trigger type 7 -> empty_payload=1, empty_event=0, acq_trigger pulses.
4. Hold ready=0, two triggers 3 cycles apart -> first word held stable, second dropped: dropped_count=1, overflow=1; next accepted trigger shows trig_num jumped by 2.
5. ttc_counter_reset + ttc_trigger same cycle after 10 triggers -> word trig_num=1, event_num=1, ts=0.
6. Force trig_num=24'hFFFFFF, trigger -> trig_num=0. With dropped_count at all-ones, a further drop holds all-ones.

Source files
------------

// File: rtl/trigger_pkg.sv
// trigger_pkg: trigger-FIFO word bit positions, acquisition strobe payload and buffer FSM states.
package trigger_pkg;
   localparam int WORD_WIDTH        = 128;
   localparam int EMPTY_PAYLOAD_BIT = 102;
   localparam int XADC_HI           = 101;
   localparam int XADC_LO           = 98;
   localparam int EMPTY_EVENT_BIT   = 97;
   localparam int TYPE_HI           = 96;
   localparam int TYPE_LO           = 92;
   localparam int EVNUM_HI          = 91;
   localparam int EVNUM_LO          = 68;
   localparam int TRIGNUM_HI        = 67;
   localparam int TRIGNUM_LO        = 44;
   localparam int TS_HI             = 43;
   localparam int TS_LO             = 0;

   typedef enum logic [1:0] {EMPTY, FULL, DROP} buf_state_t;

   typedef struct packed {
      logic [4:0]  trig_type;
      logic [23:0] trig_num;
   } acq_t;

   function automatic logic [WORD_WIDTH-1:0] pack_word(
      input logic                   empty_payload,
      input logic [3:0]             alarms,
      input logic                   empty_event,
      input logic [4:0]             trig_type,
      input logic [23:0]            event_num,
      input logic [23:0]            trig_num,
      input logic [TS_HI-TS_LO:0]   timestamp
   );
      logic [WORD_WIDTH-1:0] w;
      w                          = '0;
      w[EMPTY_PAYLOAD_BIT]       = empty_payload;
      w[XADC_HI:XADC_LO]         = alarms;
      w[EMPTY_EVENT_BIT]         = empty_event;
      w[TYPE_HI:TYPE_LO]         = trig_type;
      w[EVNUM_HI:EVNUM_LO]       = event_num;
      w[TRIGNUM_HI:TRIGNUM_LO]   = trig_num;
      w[TS_HI:TS_LO]             = timestamp;
      return w;
   endfunction
endpackage

// File: rtl/trigger_word_buffer.sv
// trigger_word_buffer: one-entry valid/ready holding register; flags triggers that arrive while a word is stuck.
module trigger_word_buffer
   import trigger_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  trigger,
   input  logic [WORD_WIDTH-1:0] word,
   input  logic                  ready,
   output logic [WORD_WIDTH-1:0] data,
   output logic                  valid,
   output logic                  load,
   output logic                  drop
);
   buf_state_t state, state_next;
   logic held;

   always_ff @(posedge clk) begin
      state <= reset ? EMPTY : state_next;
      data  <= reset ? '0 : load ? word : data;
   end

   always_comb begin
      held       = state != EMPTY;
      state_next = (!held || ready) ? (trigger ? FULL : EMPTY) : (trigger ? DROP : state);
   end

   always_comb begin
      valid = held;
      load  = trigger & (~held | ready);
      drop  = trigger & held & ~ready;
   end
endmodule

// File: rtl/ttc_trigger_packer.sv
// ttc_trigger_packer: packs TTC trigger strobes into 128-bit trigger-FIFO words and acquisition strobes.
// TRIG_XADC_ALARMS_EN: when defined, word bits [101:98] carry xadc_alarms; otherwise they read 0.
module ttc_trigger_packer
   import trigger_pkg::*;
#(
   parameter int DROP_CNT_WIDTH = 16,
   parameter int TS_WIDTH       = 44
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ttc_trigger,
   input  logic [4:0]                ttc_trig_type,
   input  logic                      ttc_counter_reset,
   input  logic [31:0]               type_enable,
   input  logic [31:0]               payload_enable,
   input  logic [3:0]                xadc_alarms,
   output logic [WORD_WIDTH-1:0]     trig_fifo_data,
   output logic                      trig_fifo_valid,
   input  logic                      trig_fifo_ready,
   output logic                      acq_trigger,
   output logic [4:0]                acq_trig_type,
   output logic [23:0]               acq_trig_num,
   output logic [DROP_CNT_WIDTH-1:0] dropped_count,
   output logic                      overflow
);
`ifdef TRIG_XADC_ALARMS_EN
   localparam logic XADC_EN = 1'b1;
`else
   localparam logic XADC_EN = 1'b0;
`endif

   logic [TS_WIDTH-1:0]   ts, cur_ts;
   logic [23:0]           trig_num, event_num, cur_trig, cur_ev, next_trig, next_ev;
   logic                  empty_event, empty_payload, load, drop;
   logic [3:0]            alarms;
   logic [WORD_WIDTH-1:0] word;
   acq_t                  acq;

   // a counter reset in the same cycle as a trigger takes effect before that trigger is numbered
   always_comb begin
      cur_ts        = ttc_counter_reset ? '0 : ts;
      cur_trig      = ttc_counter_reset ? '0 : trig_num;
      cur_ev        = ttc_counter_reset ? '0 : event_num;
      empty_event   = ~type_enable[ttc_trig_type];
      empty_payload = ~payload_enable[ttc_trig_type] & ~empty_event;
      next_trig     = cur_trig + 24'd1;
      next_ev       = empty_event ? cur_ev : cur_ev + 24'd1;
      alarms        = xadc_alarms & {4{XADC_EN}};
      word          = pack_word(empty_payload, alarms, empty_event, ttc_trig_type, next_ev, next_trig, cur_ts);
   end

   trigger_word_buffer u_buf (
      .clk     (clk),
      .reset   (reset),
      .trigger (ttc_trigger),
      .word    (word),
      .ready   (trig_fifo_ready),
      .data    (trig_fifo_data),
      .valid   (trig_fifo_valid),
      .load    (load),
      .drop    (drop)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ts            <= '0;
         trig_num      <= '0;
         event_num     <= '0;
         acq_trigger   <= 1'b0;
         acq           <= '0;
         dropped_count <= '0;
         overflow      <= 1'b0;
      end else begin
         ts          <= cur_ts + 1'b1;
         trig_num    <= ttc_trigger ? next_trig : cur_trig;
         event_num   <= load ? next_ev : cur_ev;
         acq_trigger <= load & ~empty_event;
         if (load & ~empty_event) acq <= '{trig_type: ttc_trig_type, trig_num: next_trig};
         if (drop) begin
            dropped_count <= dropped_count + {{(DROP_CNT_WIDTH-1){1'b0}}, ~&dropped_count};
            overflow      <= 1'b1;
         end
      end
   end

   assign acq_trig_type = acq.trig_type;
   assign acq_trig_num  = acq.trig_num;
endmodule

// File: tb/tb_ttc_trigger_packer.sv
// tb_ttc_trigger_packer: directed vector table, random traffic against a reference model, counter-wrap corners.
module tb_ttc_trigger_packer;
   logic         clk = 1'b0;
   logic         reset;
   logic         ttc_trigger, ttc_counter_reset, trig_fifo_ready;
   logic [4:0]   ttc_trig_type;
   logic [31:0]  type_enable, payload_enable;
   logic [3:0]   xadc_alarms;
   logic [127:0] trig_fifo_data;
   logic         trig_fifo_valid, acq_trigger, overflow;
   logic [4:0]   acq_trig_type;
   logic [23:0]  acq_trig_num;
   logic [7:0]   dropped_count;

   int tests = 0, fails = 0;

   logic [43:0]  m_ts;
   logic [23:0]  m_tn, m_ev, m_acq_num;
   logic [4:0]   m_acq_type;
   logic [127:0] m_word;
   logic         m_full, m_acq, m_ovf;
   logic [7:0]   m_drop;

   typedef struct {
      logic        trg;
      logic [4:0]  typ;
      logic        rdy;
      logic        v, a;
      logic [23:0] tn, ev;
      logic        ee, ep;
      logic [43:0] ts;
      logic [7:0]  dc;
      logic        ov;
   } vec_t;
   vec_t tbl[11];

   ttc_trigger_packer #(.DROP_CNT_WIDTH(8), .TS_WIDTH(44)) dut (
      .clk               (clk),
      .reset             (reset),
      .ttc_trigger       (ttc_trigger),
      .ttc_trig_type     (ttc_trig_type),
      .ttc_counter_reset (ttc_counter_reset),
      .type_enable       (type_enable),
      .payload_enable    (payload_enable),
      .xadc_alarms       (xadc_alarms),
      .trig_fifo_data    (trig_fifo_data),
      .trig_fifo_valid   (trig_fifo_valid),
      .trig_fifo_ready   (trig_fifo_ready),
      .acq_trigger       (acq_trigger),
      .acq_trig_type     (acq_trig_type),
      .acq_trig_num      (acq_trig_num),
      .dropped_count     (dropped_count),
      .overflow          (overflow)
   );

   always #4 clk = ~clk;

   function automatic vec_t vec(input int trg, typ, rdy, v, a, tn, ev, ee, ep, ts, dc, ov);
      vec_t r;
      r.trg = 1'(trg); r.typ = 5'(typ); r.rdy = 1'(rdy); r.v = 1'(v); r.a = 1'(a);
      r.tn = 24'(tn); r.ev = 24'(ev); r.ee = 1'(ee); r.ep = 1'(ep); r.ts = 44'(ts);
      r.dc = 8'(dc); r.ov = 1'(ov);
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, advance the reference model by the trigger rules, compare after the edge.
   task automatic step(input logic trg, input logic [4:0] typ, input logic crst, input logic rdy);
      logic [43:0] tsn;
      logic        acc, drp, ee, ep;
      logic [3:0]  alm;
      ttc_trigger = trg; ttc_trig_type = typ; ttc_counter_reset = crst; trig_fifo_ready = rdy;
      xadc_alarms = 4'($urandom);
`ifdef TRIG_XADC_ALARMS_EN
      alm = xadc_alarms;
`else
      alm = 4'd0;
`endif
      tsn = crst ? 44'd0 : m_ts;
      if (crst) begin m_tn = 0; m_ev = 0; end
      acc = trg && (!m_full || rdy);
      drp = trg && m_full && !rdy;
      ee  = !type_enable[typ];
      ep  = !payload_enable[typ] && !ee;
      if (trg) m_tn = m_tn + 24'd1;
      if (acc) begin
         if (!ee) m_ev = m_ev + 24'd1;
         m_word = {25'd0, ep, alm, ee, typ, m_ev, m_tn, tsn};
      end
      m_full = acc || (m_full && !rdy);
      m_acq  = acc && !ee;
      if (m_acq) begin m_acq_num = m_tn; m_acq_type = typ; end
      if (drp) begin
         if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
         m_ovf = 1'b1;
      end
      m_ts = tsn + 44'd1;
      @(posedge clk); #1;
      check("valid", 128'(trig_fifo_valid), 128'(m_full));
      if (m_full) check("data", trig_fifo_data, m_word);
      check("acq_trigger", 128'(acq_trigger), 128'(m_acq));
      if (m_acq) begin
         check("acq_trig_num", 128'(acq_trig_num), 128'(m_acq_num));
         check("acq_trig_type", 128'(acq_trig_type), 128'(m_acq_type));
      end
      check("dropped_count", 128'(dropped_count), 128'(m_drop));
      check("overflow", 128'(overflow), 128'(m_ovf));
      ttc_trigger = 1'b0; ttc_counter_reset = 1'b0;
   endtask

   initial begin
      tbl[0]  = vec(1, 3, 1, 1, 1, 1, 1, 0, 0, 100, 0, 0);
      tbl[1]  = vec(0, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0);
      tbl[2]  = vec(1, 5, 1, 1, 0, 2, 1, 1, 0, 102, 0, 0);
      tbl[3]  = vec(1, 7, 1, 1, 1, 3, 2, 0, 1, 103, 0, 0);
      tbl[4]  = vec(0, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0);
      tbl[5]  = vec(1, 3, 0, 1, 1, 4, 3, 0, 0, 105, 0, 0);
      tbl[6]  = vec(0, 0, 0, 1, 0, 4, 3, 0, 0, 105, 0, 0);
      tbl[7]  = vec(0, 0, 0, 1, 0, 4, 3, 0, 0, 105, 0, 0);
      tbl[8]  = vec(1, 3, 0, 1, 0, 4, 3, 0, 0, 105, 1, 1);
      tbl[9]  = vec(0, 0, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1);
      tbl[10] = vec(1, 3, 1, 1, 1, 6, 4, 0, 0, 110, 1, 1);

      reset = 1'b1; ttc_trigger = 1'b0; ttc_trig_type = 5'd0; ttc_counter_reset = 1'b0;
      trig_fifo_ready = 1'b1; xadc_alarms = 4'd0;
      type_enable = ~32'h20; payload_enable = ~32'h80;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", 128'(trig_fifo_valid), 128'd0);
      check("reset_data", trig_fifo_data, 128'd0);
      check("reset_acq", {acq_trigger, acq_trig_type, acq_trig_num}, 128'd0);
      check("reset_drop", {overflow, dropped_count}, 128'd0);
      reset = 1'b0;
      m_ts = 0; m_tn = 0; m_ev = 0; m_full = 0; m_acq = 0; m_ovf = 0; m_drop = 0;
      m_word = 0; m_acq_num = 0; m_acq_type = 0;

      repeat (100) step(1'b0, 5'd0, 1'b0, 1'b1);
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].trg, tbl[i].typ, 1'b0, tbl[i].rdy);
         check($sformatf("tbl%0d_valid", i), 128'(trig_fifo_valid), 128'(tbl[i].v));
         if (tbl[i].v) begin
            check($sformatf("tbl%0d_trignum", i), 128'(trig_fifo_data[67:44]), 128'(tbl[i].tn));
            check($sformatf("tbl%0d_evnum", i), 128'(trig_fifo_data[91:68]), 128'(tbl[i].ev));
            check($sformatf("tbl%0d_flags", i), 128'({trig_fifo_data[102], trig_fifo_data[97]}), 128'({tbl[i].ep, tbl[i].ee}));
            check($sformatf("tbl%0d_ts", i), 128'(trig_fifo_data[43:0]), 128'(tbl[i].ts));
            check($sformatf("tbl%0d_pad", i), 128'(trig_fifo_data[127:103]), 128'd0);
         end
         check($sformatf("tbl%0d_acq", i), 128'(acq_trigger), 128'(tbl[i].a));
         if (tbl[i].a) check($sformatf("tbl%0d_acqnum", i), 128'(acq_trig_num), 128'(tbl[i].tn));
         check($sformatf("tbl%0d_drop", i), 128'({overflow, dropped_count}), 128'({tbl[i].ov, tbl[i].dc}));
      end

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            type_enable = $urandom;
            payload_enable = $urandom;
         end
         step($urandom_range(0, 2) == 0, 5'($urandom), $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);
      end

      type_enable = ~32'h20; payload_enable = ~32'h80;
      step(1'b0, 5'd0, 1'b0, 1'b1);
      step(1'b1, 5'd3, 1'b1, 1'b1);
      check("crst_trignum", 128'(trig_fifo_data[67:44]), 128'd1);
      check("crst_evnum", 128'(trig_fifo_data[91:68]), 128'd1);
      check("crst_ts", 128'(trig_fifo_data[43:0]), 128'd0);
      step(1'b0, 5'd0, 1'b1, 1'b0);
      check("crst_keeps_word", 128'(trig_fifo_data[67:44]), 128'd1);

      repeat (300) step(1'b1, 5'd3, 1'b0, 1'b0);
      check("drop_saturated", 128'(dropped_count), 128'hFF);
      check("overflow_sticky", 128'(overflow), 128'd1);

      step(1'b0, 5'd0, 1'b0, 1'b1);
      force dut.trig_num = 24'hFFFFFF;
      m_tn = 24'hFFFFFF;
      step(1'b1, 5'd3, 1'b0, 1'b1);
      check("trignum_wrap", 128'(trig_fifo_data[67:44]), 128'd0);
      release dut.trig_num;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
